// File: rtl/fifo_burst_reader.sv
// Burst drain engine for a FWFT FIFO: pops bursts into a 2-entry skid buffer feeding a valid/ready stream.
// Optional partial-burst timeout is compiled in with `define FIFO_BURST_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 512,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [WIDTH-1:0]         fifo_dout,
  input  logic                     fifo_empty,
  input  logic [$clog2(DEPTH)-1:0] fifo_data_count,
  output logic                     fifo_rd_en,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam int BL_W  = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_THRESH = CNT_W'(BURST_LEN);
  localparam logic [BL_W-1:0]  BURST_MAX    = BL_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [BL_W-1:0]   beats_left_q, beats_left_d;
  logic [WIDTH-1:0]  head_data_p1, tail_data_p1;
  logic              head_last_p1, tail_last_p1;
  logic [1:0]        buf_cnt_q;
  logic              enq, deq, enq_last, start;

  function automatic logic [BL_W-1:0] clip_len(input logic [CNT_W-1:0] cnt);
    return (cnt >= BURST_THRESH) ? BURST_MAX : BL_W'(cnt);
  endfunction

`ifdef FIFO_BURST_TIMEOUT_EN
  localparam int TM_W = $clog2(TIMEOUT + 1);
  localparam logic [TM_W-1:0] TIMER_MAX = TM_W'(TIMEOUT);

  logic [TM_W-1:0] timer_q;

  function automatic logic [TM_W-1:0] sat_inc(input logic [TM_W-1:0] v);
    return (v == TIMER_MAX) ? v : v + TM_W'(1);
  endfunction

  assign start = (state_q == IDLE) &&
                 ((fifo_data_count >= BURST_THRESH) || (timer_q == TIMER_MAX && !fifo_empty));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      timer_q <= '0;
    else if (state_q != IDLE || fifo_empty || start)
      timer_q <= '0;
    else
      timer_q <= sat_inc(timer_q);
  end
`else
  assign start = (state_q == IDLE) && (fifo_data_count >= BURST_THRESH);
`endif

  assign m_valid  = (buf_cnt_q != 2'd0);
  assign m_data   = head_data_p1;
  assign m_last   = m_valid && head_last_p1;
  assign busy     = (state_q != IDLE);
  assign deq      = m_valid && m_ready;
  assign enq      = fifo_rd_en;
  assign enq_last = (beats_left_q == BL_W'(1));

  // A full buffer may still accept a pop when its head leaves in the same cycle.
  assign fifo_rd_en = (state_q == BURST) && !fifo_empty && (beats_left_q != '0) &&
                      ((buf_cnt_q != 2'd2) || deq);

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = BURST;
          beats_left_d = clip_len(fifo_data_count);
        end
      end
      BURST: begin
        if (enq) begin
          beats_left_d = beats_left_q - BL_W'(1);
          if (enq_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (deq && m_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
    end
  end

  // Output buffer stage: head entry drives the stream, tail absorbs one stalled pop.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head_data_p1 <= '0;
      tail_data_p1 <= '0;
      head_last_p1 <= 1'b0;
      tail_last_p1 <= 1'b0;
      buf_cnt_q    <= 2'd0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (buf_cnt_q == 2'd0) begin
            head_data_p1 <= fifo_dout;
            head_last_p1 <= enq_last;
          end else begin
            tail_data_p1 <= fifo_dout;
            tail_last_p1 <= enq_last;
          end
          buf_cnt_q <= buf_cnt_q + 2'd1;
        end
        2'b01: begin
          head_data_p1 <= tail_data_p1;
          head_last_p1 <= tail_last_p1;
          buf_cnt_q    <= buf_cnt_q - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_q == 2'd1) begin
            head_data_p1 <= fifo_dout;
            head_last_p1 <= enq_last;
          end else begin
            head_data_p1 <= tail_data_p1;
            head_last_p1 <= tail_last_p1;
            tail_data_p1 <= fifo_dout;
            tail_last_p1 <= enq_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FWFT FIFO feeds the DUT, and a transaction-level model predicts the stream.
module tb_fifo_burst_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int BL    = 4;
  localparam int TO    = 8;

  logic                     clk = 1'b0;
  logic                     arst_n;
  logic [WIDTH-1:0]         fifo_dout;
  logic                     fifo_empty;
  logic [$clog2(DEPTH)-1:0] fifo_data_count;
  logic                     fifo_rd_en;
  logic [WIDTH-1:0]         m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_last;
  logic                     busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_data_count(fifo_data_count),
    .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] fq[$];     // physical FIFO contents, popped by the DUT's strobe
  logic [7:0] mq[$];     // model's view of the FIFO
  logic [7:0] pend[$];   // words waiting to be written
  logic [8:0] exp_q[$];  // popped-but-unaccepted words: {last, data}
  int mb, rem, tmr, acc_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty      = (fq.size() == 0);
    fifo_dout       = (fq.size() > 0) ? fq[0] : 8'h00;
    fifo_data_count = 4'(fq.size());
  endtask

  task automatic push_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) pend.push_back(base + 8'(i));
  endtask

  // One clock cycle: drive m_ready, check outputs against the model, advance model and FIFO.
  task automatic step(input logic rdy);
    logic       exp_rd, exp_valid, dut_rd, accept, was_last, start, lb;
    logic [8:0] head;
    m_ready = rdy;
    #1;
    exp_valid = (exp_q.size() > 0);
    head      = exp_valid ? exp_q[0] : 9'h0;
    exp_rd    = (mb != 0) && (rem > 0) && (mq.size() > 0) &&
                ((exp_q.size() < 2) || (exp_valid && rdy));
    check_eq("rd_en", fifo_rd_en, exp_rd);
    check_eq("m_valid", m_valid, exp_valid);
    check_eq("busy", busy, mb != 0);
    check_eq("m_last", m_last, exp_valid && head[8]);
    if (exp_valid) check_eq("m_data", m_data, head[7:0]);
    dut_rd   = fifo_rd_en;
    accept   = exp_valid && rdy;
    was_last = accept && head[8];
    if (accept) begin
      void'(exp_q.pop_front());
      acc_cnt = was_last ? 0 : acc_cnt + 1;
    end
    if (exp_rd) begin
      lb = (rem == 1);
      exp_q.push_back({lb, mq[0]});
      void'(mq.pop_front());
      rem--;
    end
    if (mb == 0) begin
      start = (mq.size() >= BL);
`ifdef FIFO_BURST_TIMEOUT_EN
      start = start || (tmr == TO && mq.size() > 0);
`endif
      if (start) begin
        mb  = 1;
        rem = (mq.size() >= BL) ? BL : mq.size();
        tmr = 0;
      end else begin
        tmr = (mq.size() == 0) ? 0 : ((tmr < TO) ? tmr + 1 : tmr);
      end
    end else if (was_last) begin
      mb = 0;
    end
    while (pend.size() > 0 && fq.size() < DEPTH - 1) begin
      fq.push_back(pend[0]);
      mq.push_back(pend[0]);
      void'(pend.pop_front());
    end
    @(posedge clk);
    if (dut_rd && fq.size() > 0) void'(fq.pop_front());
    #1;
    drive_fifo();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n  = 1'b0;
    m_ready = 1'b0;
    mb = 0; rem = 0; tmr = 0; acc_cnt = 0;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_rd_en", fifo_rd_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_m_last", m_last, 1'b0);
    check_eq("rst_m_data", m_data, 8'h00);
    arst_n = 1'b1;

    // single burst, free-running sink
    push_words(8'hA0, 4);
    repeat (12) step(1'b1);

    // two bursts with alternating backpressure
    push_words(8'h10, 8);
    for (int i = 0; i < 40; i++) step(i % 2 == 0);

    // short residue: timeout burst if enabled, otherwise waits for more data
    push_words(8'h55, 1);
    push_words(8'h66, 1);
    repeat (120) step(1'b1);
    push_words(8'h77, 1);
    push_words(8'h88, 1);
    repeat (20) step(1'b1);

    // long stall at the start of a burst
    push_words(8'hC0, 4);
    repeat (20) step(1'b0);
    repeat (12) step(1'b1);

    // random traffic and random backpressure
    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) pend.push_back(8'($urandom));
      step($urandom_range(0, 3) != 0);
    end
    repeat (40) step(1'b1);

    // asynchronous reset after two accepted beats of a burst
    push_words(8'hE0, 8);
    for (int i = 0; i < 80 && !(mb != 0 && acc_cnt == 2); i++) step(1'b1);
    check_eq("two_beats_reached", acc_cnt, 2);
    #2;
    arst_n = 1'b0;
    #1;
    check_eq("arst_m_valid", m_valid, 1'b0);
    check_eq("arst_rd_en", fifo_rd_en, 1'b0);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_m_data", m_data, 8'h00);
    mb = 0; rem = 0; tmr = 0; acc_cnt = 0;
    exp_q.delete();
    mq = fq;
    @(posedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    repeat (40) step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
